// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit.
//
// Moore FSM that sequences fetch, decode, execute, memory and write-back
// for lw, sw, R-type, jr, beq, addi, j and jal. Memory-facing states
// (FETCH, MEMRD, MEMWR) stretch to MEM_WAIT+1 cycles and fire their
// strobes only in the final cycle. A retired-instruction counter advances
// on the edge that leaves each instruction's last state.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   opcode, funct, zero instruction fields and ALU zero flag
//   pcWrite .. pcSrc    datapath enables and mux selects
//   state               current state encoding (debug)
//   illegal             one-cycle pulse in DECODE on an unsupported opcode
//   instrCount          retired-instruction count, wraps at 2^CNT_W
module multicycle_control #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcWrite,
    output logic             iOrD,
    output logic             irWrite,
    output logic             memWrite,
    output logic [1:0]       memToReg,
    output logic [1:0]       regDst,
    output logic             regWriteEnable,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSrc,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instrCount
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wait_done;
    logic             retire;

    always_comb begin
        state_d        = state_q;
        wait_d         = '0;  // any state change re-enters with a cleared counter
        count_d        = count_q;
        retire         = 1'b0;
        wait_done      = (wait_q == WAIT_LAST);
        pcWrite        = 1'b0;
        iOrD           = 1'b0;
        irWrite        = 1'b0;
        memWrite       = 1'b0;
        memToReg       = 2'b00;
        regDst         = 2'b00;
        regWriteEnable = 1'b0;
        aluSrcA        = 1'b0;
        aluSrcB        = 2'b00;
        aluOp          = 2'b00;
        pcSrc          = 2'b00;
        illegal        = 1'b0;

        unique case (state_q)
            FETCH: begin
                aluSrcB = 2'b01;
                if (wait_done) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DECODE: begin
                aluSrcB = 2'b11;
                unique case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? JR : EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iOrD = 1'b1;
                if (wait_done) state_d = MEMWB;
                else           wait_d  = wait_q + 4'd1;
            end
            MEMWB: begin
                memToReg       = 2'b01;
                regWriteEnable = 1'b1;
                retire         = 1'b1;
                state_d        = FETCH;
            end
            MEMWR: begin
                iOrD = 1'b1;
                if (wait_done) begin
                    memWrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regDst         = 2'b01;
                regWriteEnable = 1'b1;
                retire         = 1'b1;
                state_d        = FETCH;
            end
            BRANCH: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b01;
                pcSrc   = 2'b01;
                pcWrite = zero;
                retire  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regWriteEnable = 1'b1;
                retire         = 1'b1;
                state_d        = FETCH;
            end
            JUMP: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                // Link and jump share one cycle: WD3 takes PC, which still holds PC+4.
                pcSrc          = 2'b10;
                pcWrite        = 1'b1;
                regDst         = 2'b10;
                memToReg       = 2'b10;
                regWriteEnable = 1'b1;
                retire         = 1'b1;
                state_d        = FETCH;
            end
            JR: begin
                pcSrc   = 2'b11;
                pcWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (retire) count_d = count_q + CNT_W'(1);

        // Reset is synchronous for state, but strobes are gated immediately so
        // an abandoned instruction cannot write anything in its last cycle.
        if (reset) begin
            pcWrite        = 1'b0;
            irWrite        = 1'b0;
            memWrite       = 1'b0;
            regWriteEnable = 1'b0;
            illegal        = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    assign state      = state_q;
    assign instrCount = count_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles per memory access (0..15).
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clock  in  1  sole clock, rising-edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- pcWrite  out  1  PC register enable (branch condition already folded in).
- iOrD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  instruction register enable.
- memWrite  out  1  memory write enable.
- memToReg  out  2  WD3 select: 00 ALUOut, 01 MDR, 10 PC.
- regDst  out  2  A3 select: 00 rt, 01 rd, 10 constant 31.
- regWriteEnable  out  1  register file write enable.
- aluSrcA  out  1  0 = PC, 1 = A register.
- aluSrcB  out  2  00 B, 01 constant 4, 10 SignImm, 11 SignImm<<2.
- aluOp  out  2  00 add, 01 subtract, 10 decode funct.
- pcSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 RD1 (jr).
- state  out  4  current state encoding, for debug.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- instrCount  out  CNT_W  count of retired instructions.

Function
REQ-004 SHALL implement these states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, JR 13.
REQ-005 FETCH SHALL drive iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00; it SHALL assert irWrite and pcWrite only in its final cycle.
REQ-006 DECODE SHALL drive aluSrcA=0, aluSrcB=11, aluOp=00, which precomputes the branch target.
REQ-007 DECODE dispatch SHALL be:
- 100011 (lw) and 101011 (sw) -> MEMADR.
- 000000 with funct 001000 -> JR; any other 000000 -> EXEC.
- 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; 000011 -> JAL.
- any other opcode -> FETCH, with illegal pulsed for that one cycle.
REQ-008 MEMADR and ADDIEX SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00. MEMADR -> MEMRD for lw, MEMWR for sw; ADDIEX -> ADDIWB.
REQ-009 MEMRD SHALL drive iOrD=1 and go to MEMWB. MEMWR SHALL drive iOrD=1, assert memWrite only in its final cycle, then go to FETCH.
REQ-010 Write-back states SHALL assert regWriteEnable for exactly one cycle, then go to FETCH:
- MEMWB: regDst=00, memToReg=01.
- ALUWB: regDst=01, memToReg=00.
- ADDIWB: regDst=00, memToReg=00.
REQ-011 EXEC SHALL drive aluSrcA=1, aluSrcB=00, aluOp=10, then go to ALUWB.
REQ-012 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, with pcWrite=zero, then go to FETCH.
REQ-013 JUMP SHALL drive pcSrc=10 and pcWrite=1, then go to FETCH.
REQ-014 JAL SHALL drive pcSrc=10, pcWrite=1, regDst=10, memToReg=10 and regWriteEnable=1 in the same cycle (PC still holds PC+4), then go to FETCH.
REQ-015 JR SHALL drive pcSrc=11 and pcWrite=1, then go to FETCH.
REQ-016 Wait handling:
- FETCH, MEMRD and MEMWR SHALL each last MEM_WAIT+1 cycles, timed by an internal wait counter.
- The counter SHALL clear on every state entry.
- Strobes in these states SHALL be asserted only in the final cycle.
REQ-017 Outputs not listed for a state SHALL be 0. Outputs SHALL be Moore, a function of state and wait counter only; the exception is pcWrite in BRANCH, which depends on zero.
REQ-018 instrCount SHALL increment by 1 on the edge leaving MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH (taken or not), JUMP, JAL or JR. It SHALL NOT increment on the illegal path, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-019 Latency with MEM_WAIT=0, in cycles: lw 5; sw, R-type, addi 4; beq, j, jal, jr 3.

Reset
REQ-020 When reset is high at a rising edge: state SHALL become FETCH, the wait counter 0, and instrCount 0.
REQ-021 While reset is high, pcWrite, irWrite, memWrite, regWriteEnable and illegal SHALL be forced to 0.
REQ-022 Reset asserted mid-instruction (including within a wait cycle) SHALL abandon that instruction with no further strobes and no instrCount increment.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- MEM_WAIT=0, opcode 100011 -> states 0,1,2,3,4; regWriteEnable high only in state 4, memToReg=01; instrCount goes 0 -> 1.
- MEM_WAIT=2, opcode 101011 -> FETCH lasts 3 cycles with irWrite only in the 3rd; MEMWR lasts 3 cycles with memWrite only in the 3rd; 8 cycles total.
- opcode 000100 with zero=0, then zero=1 -> pcWrite 0, then 1 in BRANCH; instrCount +2.
- opcode 000011 -> in JAL: pcWrite=1, regWriteEnable=1, regDst=10, memToReg=10, pcSrc=10.
- opcode 111111 -> illegal pulses for 1 cycle in DECODE; next state FETCH; instrCount unchanged.
- CNT_W=4, 16 R-type instructions -> instrCount wraps to 0. Then reset asserted in EXEC -> next cycle state=0 and no regWriteEnable pulse.
